// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch stage: issues one word fetch at a time, holds the returned
// instruction with its PC until the core accepts it, then steers to the next PC.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        core_ready,
  input  logic [31:0] imm_ext,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] alu_result,
  output logic        fetch_misalign
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_pc4_q, inst_pc4_d;
  logic        misalign_q, misalign_d;
  logic [31:0] next_pc;

  // JALR outranks JAL/branch; the JALR target always has bit 0 cleared.
  function automatic logic [31:0] next_pc_f(
    input logic [31:0] cur_pc,
    input logic [31:0] imm,
    input logic        take_rel,
    input logic        take_jalr,
    input logic [31:0] jalr_tgt
  );
    logic [31:0] tgt;
    if (take_jalr) begin
      tgt = jalr_tgt & 32'hFFFF_FFFE;
    end else if (take_rel) begin
      tgt = cur_pc + imm;
    end else begin
      tgt = cur_pc + 32'd4;
    end
    return tgt;
  endfunction

  assign next_pc = next_pc_f(inst_pc_q, imm_ext, jump | branch_taken, jalr, alu_result);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = 1'b0;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    inst_pc4_d   = inst_pc4_q;
    misalign_d   = misalign_q;
    case (state_q)
      S_BOOT: begin
        imem_req_d = 1'b1;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data arriving in any other state is stale and dropped.
        if (imem_rvalid) begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          inst_pc4_d   = pc_q + 32'd4;
          inst_valid_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_ready) begin
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d       = next_pc;
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= RESET_PC;
      inst_pc4_q   <= RESET_PC + 32'd4;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_pc4_q   <= inst_pc4_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req       = imem_req_q;
  assign imem_addr      = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = inst_valid_q;
  assign inst_pc        = inst_pc_q;
  assign inst_pc4       = inst_pc4_q;
  assign fetch_misalign = misalign_q;

endmodule
